// File: rtl/rob_multiport_if.sv
// rtl/rob_multiport_if.sv - dispatch/CDB/read/retire/recovery bundle for rob_multiport
interface rob_multiport_if #(
  parameter int DEPTH    = 32,
  parameter int XLEN     = 32,
  parameter int N_CDB    = 2,
  parameter int N_READ   = 2,
  parameter int RETIRE_W = 2
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       disp_valid;
  logic [4:0]                 disp_dest;
  logic                       disp_reg_wr;
  logic                       disp_is_mem;
  logic [IDX_W-1:0]           disp_tag;
  logic                       rob_full;
  logic                       rob_empty;

  logic [N_CDB-1:0]           cdb_valid;
  logic [N_CDB*IDX_W-1:0]     cdb_tag;
  logic [N_CDB*XLEN-1:0]      cdb_value;

  logic [N_READ*IDX_W-1:0]    rd_tag;
  logic [N_READ-1:0]          rd_ready;
  logic [N_READ*XLEN-1:0]     rd_value;

  logic                       retire_en;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W*IDX_W-1:0]  retire_tag;
  logic [RETIRE_W*5-1:0]      retire_dest;
  logic [RETIRE_W*XLEN-1:0]   retire_value;
  logic [RETIRE_W-1:0]        retire_reg_wr;
  logic [RETIRE_W-1:0]        retire_is_mem;

  logic                       squash_valid;
  logic [IDX_W-1:0]           squash_tag;
  logic                       rob_clear;
  logic [CNT_W-1:0]           rob_count;

  modport slave (
    input  disp_valid, disp_dest, disp_reg_wr, disp_is_mem,
    output disp_tag, rob_full, rob_empty,
    input  cdb_valid, cdb_tag, cdb_value,
    input  rd_tag,
    output rd_ready, rd_value,
    input  retire_en,
    output retire_valid, retire_tag, retire_dest, retire_value, retire_reg_wr, retire_is_mem,
    input  squash_valid, squash_tag, rob_clear,
    output rob_count
  );

  modport master (
    output disp_valid, disp_dest, disp_reg_wr, disp_is_mem,
    input  disp_tag, rob_full, rob_empty,
    output cdb_valid, cdb_tag, cdb_value,
    output rd_tag,
    input  rd_ready, rd_value,
    output retire_en,
    input  retire_valid, retire_tag, retire_dest, retire_value, retire_reg_wr, retire_is_mem,
    output squash_valid, squash_tag, rob_clear,
    input  rob_count
  );
endinterface

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - in-order reorder buffer with multi-port CDB, operand reads, wide retire and partial squash
module rob_multiport #(
  parameter int DEPTH    = 32,
  parameter int XLEN     = 32,
  parameter int N_CDB    = 2,
  parameter int N_READ   = 2,
  parameter int RETIRE_W = 2
) (
  input logic           clock,
  input logic           reset,
  rob_multiport_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] occ_q, done_q, reg_wr_q, is_mem_q;
  logic [4:0]       dest_q  [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];

  logic [DEPTH-1:0] cdb_hit;
  logic [XLEN-1:0]  cdb_val [DEPTH];
  logic [DEPTH-1:0] squashed;
  logic [IDX_W-1:0] squash_off;
  logic [IDX_W-1:0] ret_idx [RETIRE_W];
  logic [CNT_W-1:0] n_ret;
  logic             ret_run;
  logic             disp_fire;

  assign bus.rob_full  = (count_q == CNT_W'(DEPTH));
  assign bus.rob_empty = (count_q == '0);
  assign bus.rob_count = count_q;
  assign bus.disp_tag  = tail_q;
  assign disp_fire     = bus.disp_valid & ~bus.rob_full;
  assign squash_off    = bus.squash_tag - head_q;

  // Per-entry CDB match; scanning high to low leaves the lowest port as winner.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cdb_hit[i] = 1'b0;
      cdb_val[i] = '0;
      for (int p = N_CDB - 1; p >= 0; p--) begin
        if (bus.cdb_valid[p] && bus.cdb_tag[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
          cdb_hit[i] = 1'b1;
          cdb_val[i] = bus.cdb_value[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Entries strictly younger than squash_tag, measured as distance from head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      squashed[i] = bus.squash_valid & occ_q[i] & ((IDX_W'(i) - head_q) > squash_off);
    end
  end

  always_comb begin
    bus.rd_ready = '0;
    bus.rd_value = '0;
    for (int r = 0; r < N_READ; r++) begin
      if (done_q[bus.rd_tag[r*IDX_W +: IDX_W]]) begin
        bus.rd_ready[r]              = 1'b1;
        bus.rd_value[r*XLEN +: XLEN] = value_q[bus.rd_tag[r*IDX_W +: IDX_W]];
      end else if (occ_q[bus.rd_tag[r*IDX_W +: IDX_W]] && cdb_hit[bus.rd_tag[r*IDX_W +: IDX_W]]) begin
        bus.rd_ready[r]              = 1'b1;
        bus.rd_value[r*XLEN +: XLEN] = cdb_val[bus.rd_tag[r*IDX_W +: IDX_W]];
      end
    end
  end

  // Retire a contiguous DONE prefix from head; never past a same-cycle squash point.
  always_comb begin
    bus.retire_valid  = '0;
    bus.retire_tag    = '0;
    bus.retire_dest   = '0;
    bus.retire_value  = '0;
    bus.retire_reg_wr = '0;
    bus.retire_is_mem = '0;
    n_ret             = '0;
    ret_run           = bus.retire_en & ~bus.rob_clear & ~reset;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_idx[k] = head_q + IDX_W'(k);
      if (bus.squash_valid && (IDX_W'(k) > squash_off)) ret_run = 1'b0;
      ret_run = ret_run & occ_q[ret_idx[k]] & done_q[ret_idx[k]];
      bus.retire_valid[k]              = ret_run;
      bus.retire_tag[k*IDX_W +: IDX_W] = ret_idx[k];
      bus.retire_dest[k*5 +: 5]        = dest_q[ret_idx[k]];
      bus.retire_value[k*XLEN +: XLEN] = value_q[ret_idx[k]];
      bus.retire_reg_wr[k]             = reg_wr_q[ret_idx[k]];
      bus.retire_is_mem[k]             = is_mem_q[ret_idx[k]];
      if (ret_run) n_ret = n_ret + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.rob_clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i] && !done_q[i] && cdb_hit[i] && !squashed[i]) begin
          done_q[i]  <= 1'b1;
          value_q[i] <= cdb_val[i];
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (bus.retire_valid[k]) begin
          occ_q[ret_idx[k]]  <= 1'b0;
          done_q[ret_idx[k]] <= 1'b0;
        end
      end
      head_q <= head_q + IDX_W'(n_ret);
      if (bus.squash_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (squashed[i]) begin
            occ_q[i]  <= 1'b0;
            done_q[i] <= 1'b0;
          end
        end
        tail_q  <= bus.squash_tag + IDX_W'(1);
        count_q <= CNT_W'(squash_off) + CNT_W'(1) - n_ret;
      end else if (disp_fire) begin
        occ_q[tail_q]    <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        dest_q[tail_q]   <= bus.disp_dest;
        reg_wr_q[tail_q] <= bus.disp_reg_wr;
        is_mem_q[tail_q] <= bus.disp_is_mem;
        tail_q           <= tail_q + IDX_W'(1);
        count_q          <= count_q + CNT_W'(1) - n_ret;
      end else begin
        count_q <= count_q - n_ret;
      end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - directed self-checking bench for rob_multiport (DEPTH=8, 2 CDB, 2 read, 2 retire)
module tb_rob_multiport;
  localparam int DEPTH    = 8;
  localparam int XLEN     = 32;
  localparam int N_CDB    = 2;
  localparam int N_READ   = 2;
  localparam int RETIRE_W = 2;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  rob_multiport_if #(.DEPTH(DEPTH), .XLEN(XLEN), .N_CDB(N_CDB), .N_READ(N_READ), .RETIRE_W(RETIRE_W)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .XLEN(XLEN), .N_CDB(N_CDB), .N_READ(N_READ), .RETIRE_W(RETIRE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.disp_valid   = 1'b0;
    bus.disp_dest    = '0;
    bus.disp_reg_wr  = 1'b0;
    bus.disp_is_mem  = 1'b0;
    bus.cdb_valid    = '0;
    bus.cdb_tag      = '0;
    bus.cdb_value    = '0;
    bus.rd_tag       = '0;
    bus.retire_en    = 1'b0;
    bus.squash_valid = 1'b0;
    bus.squash_tag   = '0;
    bus.rob_clear    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cdb(input int p, input logic [2:0] tag, input logic [31:0] val);
    bus.cdb_valid[p]         = 1'b1;
    bus.cdb_tag[p*3 +: 3]    = tag;
    bus.cdb_value[p*32 +: 32] = val;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    bus.retire_en = 1'b1;
    #1;
    check("rst_empty", bus.rob_empty, 1);
    check("rst_full", bus.rob_full, 0);
    check("rst_count", bus.rob_count, 0);
    check("rst_retire_valid", bus.retire_valid, 0);
    check("rst_rd_ready", bus.rd_ready, 0);
    check("rst_disp_tag", bus.disp_tag, 0);
    tick();

    // three dispatches, dest 1..3
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.disp_valid = 1'b1;
      bus.disp_dest  = 5'(i + 1);
      bus.disp_reg_wr = 1'b1;
      #1;
      check("disp_tag_first3", bus.disp_tag, i);
      tick();
    end
    idle();
    bus.rd_tag[2:0] = 3'd1;
    #1;
    check("count_3", bus.rob_count, 3);
    check("rd_busy_tag1", bus.rd_ready[0], 0);

    // dual CDB in one cycle; retire appears one cycle later
    idle();
    cdb(0, 3'd1, 32'hFFFF_FFFF);
    cdb(1, 3'd0, 32'h5);
    bus.retire_en   = 1'b1;
    bus.rd_tag[2:0] = 3'd1;
    #1;
    check("retire_same_cycle_cdb", bus.retire_valid, 0);
    check("rd_bypass_tag1_ready", bus.rd_ready[0], 1);
    check("rd_bypass_tag1_value", bus.rd_value[31:0], 32'hFFFF_FFFF);
    tick();
    idle();
    bus.retire_en = 1'b1;
    #1;
    check("retire_valid_11", bus.retire_valid, 2'b11);
    check("retire_value0", bus.retire_value[31:0], 32'h5);
    check("retire_value1", bus.retire_value[63:32], 32'hFFFF_FFFF);
    check("retire_tag", bus.retire_tag, 6'b001_000);
    check("retire_dest", bus.retire_dest, 10'b00010_00001);
    check("retire_reg_wr", bus.retire_reg_wr, 2'b11);
    tick();
    idle();
    #1;
    check("count_after_retire", bus.rob_count, 1);

    // complete head (tag 2) without retiring, then fill and wrap
    cdb(0, 3'd2, 32'h22);
    tick();
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.disp_valid = 1'b1;
      bus.disp_dest  = 5'(i + 4);
      #1;
      check("disp_tag_fill", bus.disp_tag, (3 + i) % 8);
      tick();
    end
    idle();
    #1;
    check("full_flag", bus.rob_full, 1);
    check("full_count", bus.rob_count, 8);

    // dispatch at full is dropped even though head retires this cycle
    bus.disp_valid = 1'b1;
    bus.retire_en  = 1'b1;
    #1;
    check("full_retire_valid", bus.retire_valid, 2'b01);
    check("full_retire_tag", bus.retire_tag[2:0], 2);
    check("full_retire_value", bus.retire_value[31:0], 32'h22);
    tick();
    idle();
    #1;
    check("drop_count", bus.rob_count, 7);
    check("drop_full", bus.rob_full, 0);
    check("drop_disp_tag", bus.disp_tag, 2);

    // clear beats CDB, dispatch and retire
    cdb(0, 3'd3, 32'h33);
    tick();
    idle();
    bus.rob_clear  = 1'b1;
    bus.retire_en  = 1'b1;
    bus.disp_valid = 1'b1;
    cdb(0, 3'd4, 32'h44);
    #1;
    check("clear_retire_valid", bus.retire_valid, 0);
    tick();
    idle();
    bus.rd_tag[2:0] = 3'd3;
    #1;
    check("clear_count", bus.rob_count, 0);
    check("clear_empty", bus.rob_empty, 1);
    check("clear_disp_tag", bus.disp_tag, 0);
    check("clear_rd_ready", bus.rd_ready[0], 0);

    // tags 0..5 live, then squash younger than tag 2
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.disp_valid = 1'b1;
      bus.disp_dest  = 5'(10 + i);
      bus.disp_is_mem = 1'b1;
      tick();
    end
    idle();
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 3'd2;
    bus.disp_valid   = 1'b1;
    cdb(0, 3'd4, 32'h44);
    tick();
    idle();
    #1;
    check("squash_count", bus.rob_count, 3);
    check("squash_disp_tag", bus.disp_tag, 3);
    cdb(0, 3'd4, 32'h44);
    bus.rd_tag[2:0] = 3'd4;
    #1;
    check("squashed_cdb_rd", bus.rd_ready[0], 0);
    tick();
    idle();
    bus.rd_tag[2:0] = 3'd4;
    #1;
    check("squashed_rd_after", bus.rd_ready[0], 0);

    // redispatch tag 3, then CDB bypass on port 1
    bus.disp_valid = 1'b1;
    #1;
    check("redisp_tag", bus.disp_tag, 3);
    tick();
    idle();
    cdb(1, 3'd3, 32'hABCD);
    bus.rd_tag[5:3] = 3'd3;
    #1;
    check("bypass_ready", bus.rd_ready[1], 1);
    check("bypass_value", bus.rd_value[63:32], 32'hABCD);
    tick();
    idle();
    cdb(0, 3'd2, 32'h111);
    cdb(1, 3'd2, 32'h222);
    bus.rd_tag[2:0] = 3'd2;
    #1;
    check("cdb_prio_bypass", bus.rd_value[31:0], 32'h111);
    tick();
    idle();
    bus.rd_tag    = {3'd3, 3'd2};
    bus.retire_en = 1'b1;
    #1;
    check("cdb_prio_stored", bus.rd_value[31:0], 32'h111);
    check("stored_tag3", bus.rd_value[63:32], 32'hABCD);
    check("stored_ready", bus.rd_ready, 2'b11);
    check("count_4", bus.rob_count, 4);
    check("retire_blocked_head", bus.retire_valid, 0);

    // reset mid-fill
    idle();
    bus.disp_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.rd_tag[2:0] = 3'd2;
    #1;
    check("rst_mid_count", bus.rob_count, 0);
    check("rst_mid_empty", bus.rob_empty, 1);
    check("rst_mid_disp_tag", bus.disp_tag, 0);
    check("rst_mid_rd_ready", bus.rd_ready[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
